// File: rtl/riscv_sw_debounce_if.sv
// Switch conditioning bus: raw pins in, debounced value, change strobe and tick out.
interface riscv_sw_debounce_if #(
  parameter int unsigned WIDTH = 24
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_out;
  logic             sw_change;
  logic             sample_tick;

  modport master (
    output sw_raw,
    input  sw_out,
    input  sw_change,
    input  sample_tick
  );

  modport slave (
    input  sw_raw,
    output sw_out,
    output sw_change,
    output sample_tick
  );
endinterface

// File: rtl/riscv_sw_debounce.sv
// Board switch conditioner: 2-flop synchroniser, shared sample prescaler,
// per-bit saturating-free debounce counters, and a 1-cycle change strobe.
module riscv_sw_debounce #(
  parameter int unsigned WIDTH          = 24,
  parameter int unsigned TICK_DIV       = 100000,
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input logic                 clk,
  input logic                 rst,
  riscv_sw_debounce_if.slave  bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(STABLE_SAMPLES) + 1;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [PW-1:0]    presc_q;
  logic [PW-1:0]    presc_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] sw_q;
  logic [WIDTH-1:0] sw_d;
  logic             change_q;
  logic             change_d;
  logic             tick;

  // Tick is decoded from the registered prescaler so it lines up with its count.
  always_comb begin
    tick    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // A sample matching the output cancels progress; S-1 prior mismatches plus this one flip.
  always_comb begin
    sw_d  = sw_q;
    cnt_d = cnt_q;
    if (tick) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync2_q[i] == sw_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CW'(STABLE_SAMPLES - 1)) begin
          sw_d[i]  = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    change_d = |(sw_d ^ sw_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      presc_q  <= '0;
      sw_q     <= '0;
      change_q <= 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= bus.sw_raw;
      sync2_q  <= sync1_q;
      presc_q  <= presc_d;
      sw_q     <= sw_d;
      change_q <= change_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.sw_out      = sw_q;
  assign bus.sw_change   = change_q;
  assign bus.sample_tick = tick;

endmodule

// File: tb/tb_riscv_sw_debounce.sv
// Self-checking bench for riscv_sw_debounce: directed vectors, corner sequences,
// and randomized bouncing inputs against a sample-history reference model.
module tb_riscv_sw_debounce;

  localparam int unsigned W  = 24;
  localparam int unsigned TD = 4;
  localparam int unsigned S  = 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n;

  riscv_sw_debounce_if #(.WIDTH(W)) bus ();

  riscv_sw_debounce #(
    .WIDTH         (W),
    .TICK_DIV      (TD),
    .STABLE_SAMPLES(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw history gives the synchronised view, every tick appends a
  // sample, and a bit flips once its last S samples since its previous flip all differ.
  logic [W-1:0] raw_q [$];
  logic [W-1:0] samp_q [$];
  int           flip_idx [W];
  logic [W-1:0] m_out;
  logic         m_chg;
  logic         m_tick;
  int           m_cyc;

  always @(posedge clk) begin
    logic [W-1:0] s2;
    logic [W-1:0] nout;
    logic [W-1:0] w;
    logic         all;
    if (rst) begin
      raw_q.delete();
      raw_q.push_back('0);
      raw_q.push_back('0);
      samp_q.delete();
      for (int i = 0; i < int'(W); i++) flip_idx[i] = 0;
      m_out  = '0;
      m_chg  = 1'b0;
      m_cyc  = 0;
      m_tick = 1'b0;
    end else if (raw_q.size() >= 2) begin
      s2 = raw_q[raw_q.size() - 2];
      raw_q.push_back(bus.sw_raw);
      if (raw_q.size() > 4) void'(raw_q.pop_front());
      nout = m_out;
      if ((m_cyc % TD) == TD - 1) begin
        samp_q.push_back(s2);
        for (int i = 0; i < int'(W); i++) begin
          if (samp_q.size() - flip_idx[i] >= int'(S)) begin
            all = 1'b1;
            for (int k = 1; k <= int'(S); k++) begin
              w = samp_q[samp_q.size() - k];
              if (w[i] == m_out[i]) all = 1'b0;
            end
            if (all) begin
              nout[i]     = ~m_out[i];
              flip_idx[i] = samp_q.size();
            end
          end
        end
      end
      m_chg  = (nout != m_out);
      m_out  = nout;
      m_cyc  = m_cyc + 1;
      m_tick = ((m_cyc % TD) == TD - 1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, n, act, exp);
    end
  endtask

  // Drive inputs for the coming edge, then land 1 time unit after it.
  task automatic step(input logic r, input logic [W-1:0] raw);
    rst        = r;
    bus.sw_raw = raw;
    @(posedge clk);
    #1;
    n = r ? 0 : n + 1;
  endtask

  task automatic do_reset();
    step(1'b1, '0);
    step(1'b1, '0);
  endtask

  typedef struct {
    logic         rst;
    logic [W-1:0] raw;
    logic [W-1:0] e_out;
    logic         e_chg;
    logic         e_tick;
  } vec_t;

  vec_t         tbl [15];
  logic [W-1:0] rv;
  logic [W-1:0] mask;
  int           rate;

  initial begin
    checks     = 0;
    errors     = 0;
    n          = 0;
    rst        = 1'b1;
    bus.sw_raw = '1;

    // Reset with pins high, then single-bit basic qualification.
    for (int i = 0; i < 2; i++) tbl[i] = '{1'b1, 24'hFFFFFF, 24'h0, 1'b0, 1'b0};
    for (int k = 1; k <= 13; k++) begin
      tbl[k + 1] = '{1'b0, 24'h000001, (k >= 12) ? 24'h000001 : 24'h0,
                     (k == 12), ((k % 4) == 3)};
    end
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].raw);
      chk("tbl_out",  32'(bus.sw_out),      32'(tbl[i].e_out));
      chk("tbl_chg",  32'(bus.sw_change),   32'(tbl[i].e_chg));
      chk("tbl_tick", 32'(bus.sample_tick), 32'(tbl[i].e_tick));
    end

    // Glitch on bit 5 never qualifies.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, (k <= 5) ? 24'h000020 : 24'h0);
      chk("glitch_out", 32'(bus.sw_out), 32'h0);
      chk("glitch_chg", 32'(bus.sw_change), 32'h0);
    end

    // Bounce on bit 3 seen by the cycle-7 tick restarts the count.
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      step(1'b0, (k >= 5 && k <= 7) ? 24'h0 : 24'h000008);
      chk("bounce_out", 32'(bus.sw_out), (k >= 20) ? 32'h8 : 32'h0);
      chk("bounce_chg", 32'(bus.sw_change), 32'(k == 20));
    end

    // Many bits flipping together give one pulse each way.
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, (k <= 12) ? 24'hA5A5A5 : 24'h0);
      chk("multi_out", 32'(bus.sw_out), (k >= 12 && k < 24) ? 32'hA5A5A5 : 32'h0);
      chk("multi_chg", 32'(bus.sw_change), 32'(k == 12 || k == 24));
    end

    // Reset mid-count discards progress; full qualification needed afterwards.
    do_reset();
    for (int k = 1; k <= 8; k++) step(1'b0, 24'h000001);
    chk("midrst_pre", 32'(bus.sw_out), 32'h0);
    step(1'b1, 24'h000001);
    chk("midrst_out",  32'(bus.sw_out), 32'h0);
    chk("midrst_chg",  32'(bus.sw_change), 32'h0);
    chk("midrst_tick", 32'(bus.sample_tick), 32'h0);
    for (int k = 1; k <= 13; k++) begin
      step(1'b0, 24'h000001);
      chk("midrst_requal", 32'(bus.sw_out), (k >= 12) ? 32'h1 : 32'h0);
    end

    // Random bouncing inputs with varying activity and occasional resets.
    do_reset();
    rv = '0;
    for (int c = 0; c < 4000; c++) begin
      if ((c % 500) == 0) rate = int'($urandom_range(2, 5));
      mask = W'($urandom);
      for (int j = 1; j < rate; j++) mask = mask & W'($urandom);
      rv = rv ^ mask;
      step(($urandom_range(0, 299) == 0), rv);
      chk("rand_out",  32'(bus.sw_out),      32'(m_out));
      chk("rand_chg",  32'(bus.sw_change),   32'(m_chg));
      chk("rand_tick", 32'(bus.sample_tick), 32'(m_tick));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
